// File: rtl/dram_arbiter_pkg.sv
// dram_arbiter_pkg: shared state encoding, width defaults and requester indices
package dram_arbiter_pkg;
    typedef enum logic [2:0] {IDLE, AR, R, AW, W, B, DONE} state_t;
    localparam int ADDR_W_DEF = 17;
    localparam int DATA_W_DEF = 64;
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;
endpackage

// File: rtl/dram_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant, favouring the requester not granted last
module rr_arbiter2
    import dram_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       any,
    output logic       grant
);
    always_comb begin
        any   = |req;
        grant = &req ? ~last_grant : (req[1] ? REQ1 : REQ0);
    end
endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter: two-requester round-robin front end onto a single AXI-like DRAM port
module dram_arbiter
    import dram_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [2*ADDR_W-1:0] addr,
    input  logic [2*DATA_W-1:0] wdata,
    output logic [1:0]        done,
    output logic [DATA_W-1:0] rdata,
    output logic              ar_valid,
    output logic [ADDR_W-1:0] ar_addr,
    input  logic              ar_ready,
    input  logic              r_valid,
    input  logic [DATA_W-1:0] r_data,
    output logic              r_ready,
    output logic              aw_valid,
    output logic [ADDR_W-1:0] aw_addr,
    input  logic              aw_ready,
    output logic              w_valid,
    output logic [DATA_W-1:0] w_data,
    input  logic              w_ready,
    input  logic              b_valid,
    output logic              b_ready
);
    state_t state, next;
    logic last_grant, cur, any, grant;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    rr_arbiter2 u_arb (.req(req), .last_grant(last_grant), .any(any), .grant(grant));

    assign ar_addr = addr_q;
    assign aw_addr = addr_q;
    assign w_data  = wdata_q;

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = any ? (we[grant] ? AW : AR) : IDLE;
            AR:      next = ar_ready ? R : AR;
            R:       next = r_valid ? DONE : R;
            AW:      next = aw_ready ? W : AW;
            W:       next = w_ready ? B : W;
            B:       next = b_valid ? DONE : B;
            default: next = IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they coincide with the state they belong to
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= REQ1;
            cur        <= REQ0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata      <= '0;
            done       <= '0;
            ar_valid   <= 1'b0;
            r_ready    <= 1'b0;
            aw_valid   <= 1'b0;
            w_valid    <= 1'b0;
            b_ready    <= 1'b0;
        end else begin
            state <= next;
            if (state == IDLE && any) begin
                cur        <= grant;
                last_grant <= grant;
                addr_q     <= grant ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
                wdata_q    <= grant ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
            end
            if (state == R && r_valid)
                rdata <= r_data;
            done     <= {next == DONE && cur, next == DONE && !cur};
            ar_valid <= next == AR;
            r_ready  <= next == R;
            aw_valid <= next == AW;
            w_valid  <= next == W;
            b_ready  <= next == B;
        end
    end
endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed checks of grant order, channel sequencing, back-pressure and reset
module tb_dram_arbiter;
    import dram_arbiter_pkg::*;

    logic        clk = 0, rst_n = 0;
    logic [1:0]  req = 0, we = 0, done;
    logic [33:0] addr = 0;
    logic [127:0] wdata = 0;
    logic [63:0] rdata, r_data = 0, w_data;
    logic [16:0] ar_addr, aw_addr;
    logic ar_valid, ar_ready = 0, r_valid = 0, r_ready;
    logic aw_valid, aw_ready = 0, w_valid, w_ready = 0, b_valid = 0, b_ready;
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    dram_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .done(done), .rdata(rdata), .ar_valid(ar_valid), .ar_addr(ar_addr), .ar_ready(ar_ready),
        .r_valid(r_valid), .r_data(r_data), .r_ready(r_ready), .aw_valid(aw_valid),
        .aw_addr(aw_addr), .aw_ready(aw_ready), .w_valid(w_valid), .w_data(w_data),
        .w_ready(w_ready), .b_valid(b_valid), .b_ready(b_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " valids"}, {ar_valid, r_ready, aw_valid, w_valid, b_ready}, 5'b0);
        check({tag, " done"}, done, 2'b00);
        check({tag, " addr"}, {ar_addr, aw_addr}, 34'h0);
        check({tag, " wdata"}, w_data, 64'h0);
        check({tag, " state"}, dut.state, IDLE);
    endtask

    task automatic wait_done(output logic [1:0] d, output int n);
        d = 0;
        n = 0;
        while (n < 20 && d == 0) begin
            tick();
            n++;
            d = done;
        end
        if (d == 0) check("wait_done timeout", 1, 0);
    endtask

    initial begin
        logic [1:0] d;
        int n;
        repeat (2) tick();
        check_idle_outputs("reset");
        check("reset rdata", rdata, 64'h0);
        check("reset last_grant", dut.last_grant, 1);
        rst_n = 1;

        // single read, zero-wait slave
        ar_ready = 1; r_valid = 1; r_data = 64'hDEAD_BEEF_0123_4567;
        addr[16:0] = 17'h10000; we = 2'b00; req = 2'b01;
        tick();
        check("rd ar_valid", ar_valid, 1);
        check("rd ar_addr", ar_addr, 17'h10000);
        check("rd done early1", done, 2'b00);
        tick();
        check("rd r_ready", r_ready, 1);
        check("rd ar_valid drop", ar_valid, 0);
        check("rd done early2", done, 2'b00);
        tick();
        check("rd done", done, 2'b01);
        check("rd rdata", rdata, 64'hDEAD_BEEF_0123_4567);
        req = 2'b00;
        tick();
        check("rd done pulse", done, 2'b00);

        // contention from a fresh reset: grants alternate 0,1,0,1
        rst_n = 0; tick(); rst_n = 1;
        addr[33:17] = 17'h00777; req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_done(d, n);
            check($sformatf("rr done %0d", i), d, (i % 2) ? 2'b10 : 2'b01);
            if (i > 0) check($sformatf("rr spacing %0d", i), n, 4);
        end
        req = 2'b00;
        tick();
        check("rr quiet", done, 2'b00);

        // write with address and data back-pressure
        ar_ready = 0; r_valid = 0;
        addr[33:17] = 17'h0ABCD; wdata[127:64] = 64'h1122_3344_5566_7788;
        we = 2'b10; req = 2'b10;
        tick();
        req = 2'b00;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("wr aw_valid %0d", i), aw_valid, 1);
            check($sformatf("wr aw_addr %0d", i), aw_addr, 17'h0ABCD);
            check($sformatf("wr no w_valid %0d", i), w_valid, 0);
            tick();
        end
        aw_ready = 1;
        check("wr aw hs w_valid", w_valid, 0);
        tick();
        aw_ready = 0;
        check("wr aw drop", aw_valid, 0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("wr w_valid %0d", i), w_valid, 1);
            check($sformatf("wr w_data %0d", i), w_data, 64'h1122_3344_5566_7788);
            tick();
        end
        w_ready = 1;
        tick();
        w_ready = 0;
        check("wr b_ready", b_ready, 1);
        check("wr w_valid drop", w_valid, 0);
        tick();
        check("wr b wait", {b_ready, done}, 3'b100);
        b_valid = 1;
        tick();
        b_valid = 0;
        check("wr done", done, 2'b10);
        check("wr rdata kept", rdata, 64'hDEAD_BEEF_0123_4567);
        tick();

        // ready already high before valid
        ar_ready = 1; addr[16:0] = 17'h00042; we = 2'b00; req = 2'b01;
        tick();
        req = 2'b00;
        check("er ar_valid", ar_valid, 1);
        check("er ar_addr", ar_addr, 17'h00042);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n += int'(ar_valid);
            check($sformatf("er r_ready %0d", i), r_ready, 1);
        end
        check("er single ar", n, 0);
        r_valid = 1; r_data = 64'hCAFE_0000_FACE_0001;
        tick();
        r_valid = 0; ar_ready = 0;
        check("er done", done, 2'b01);
        check("er rdata", rdata, 64'hCAFE_0000_FACE_0001);
        tick();

        // reset while in W abandons the write
        aw_ready = 1; addr[16:0] = 17'h01234; wdata[63:0] = 64'h55; we = 2'b01; req = 2'b01;
        tick();
        tick();
        aw_ready = 0;
        check("rs in W", w_valid, 1);
        rst_n = 0;
        tick();
        rst_n = 1; req = 2'b00;
        check_idle_outputs("rs");
        check("rs rdata", rdata, 64'h0);
        tick();
        check("rs no done", done, 2'b00);
        check("rs state", dut.state, IDLE);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
